// File: rtl/analog_axis_pkg.sv
// analog_axis_pkg
// Shared types and arithmetic helpers for the analog-axis emulator.
//   axis_state_t : per-channel mode (IDLE passthrough, MOUSE, RAMP)
//   clamp_step   : limits a signed delta to +/-lim
//   sat_add      : signed add that saturates to an aw-bit signed range
package analog_axis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOUSE = 2'd1,
        RAMP  = 2'd2
    } axis_state_t;

    function automatic int clamp_step(input int d, input int lim);
        if (d > lim)
            return lim;
        if (d < -lim)
            return -lim;
        return d;
    endfunction

    function automatic int sat_add(input int a, input int b, input int aw);
        int hi;
        int lo;
        int s;
        hi = (1 << (aw - 1)) - 1;
        lo = -(1 << (aw - 1));
        s  = a + b;
        if (s > hi)
            return hi;
        if (s < lo)
            return lo;
        return s;
    endfunction

endpackage

// File: rtl/analog_axis_chan.sv
// analog_axis_chan
// One controller channel: IDLE/MOUSE/RAMP state machine, signed X/Y
// accumulators (AW+1 bits, kept inside the AW-bit range) and the
// registered channel outputs.
// Optional feature macro: AXIS_DIGITAL_RAMP_EN (enables RAMP and dig handling).
// Ports:
//   CLK_VIDEO, reset : clock, synchronous active-high reset
//   stb              : one-cycle pulse, a mouse packet addressed to this channel
//   dx, dy           : 9-bit signed mouse deltas of that packet
//   btn              : mouse buttons of that packet
//   ana              : real stick {Y,X}
//   dig              : digital directions {U,D,L,R}
//   halt, tick       : core halted, shared ramp tick
//   ax_out, ay_out   : signed axis outputs
//   btn_out          : buttons, zero outside MOUSE
//   emu_act          : channel is in MOUSE or RAMP
module analog_axis_chan
    import analog_axis_pkg::*;
#(
    parameter int AW        = 8,
    parameter int MAX_STEP  = 10,
    parameter int RAMP_STEP = 2
) (
    input  logic              CLK_VIDEO,
    input  logic              reset,
    input  logic              stb,
    input  logic signed [8:0] dx,
    input  logic signed [8:0] dy,
    input  logic [1:0]        btn,
    input  logic [2*AW-1:0]   ana,
    input  logic [3:0]        dig,
    input  logic              halt,
    input  logic              tick,
    output logic [AW-1:0]     ax_out,
    output logic [AW-1:0]     ay_out,
    output logic [1:0]        btn_out,
    output logic              emu_act
);

    localparam int AW1 = AW + 1;

    axis_state_t        state, state_n;
    logic signed [AW:0] accx, accy, accx_n, accy_n;
    logic [1:0]         btn_n;
    logic               ovr;

    assign ovr = halt || (ana != '0);

`ifdef AXIS_DIGITAL_RAMP_EN
    // Pressed direction ramps away from centre; a released axis returns
    // toward 0 by at most RAMP_STEP; both opposite directions hold.
    function automatic int ramp_axis(input int a, input logic pos, input logic neg);
        if (pos && neg)
            return a;
        if (pos)
            return sat_add(a, RAMP_STEP, AW);
        if (neg)
            return sat_add(a, -RAMP_STEP, AW);
        if (a > RAMP_STEP)
            return a - RAMP_STEP;
        if (a < -RAMP_STEP)
            return a + RAMP_STEP;
        return 0;
    endfunction
`else
    logic unused_ramp;
    assign unused_ramp = ^{dig, tick};
`endif

    always_comb begin
        state_n = state;
        accx_n  = accx;
        accy_n  = accy;
        btn_n   = btn_out;
        if (ovr) begin
            // Override beats any strobe or tick arriving in the same cycle.
            state_n = IDLE;
            accx_n  = '0;
            accy_n  = '0;
        end else if (stb) begin
            state_n = MOUSE;
            accx_n  = AW1'(sat_add(int'(accx), clamp_step(int'(dx), MAX_STEP), AW));
            accy_n  = AW1'(sat_add(int'(accy), clamp_step(int'(dy), MAX_STEP), AW));
            btn_n   = btn;
        end else begin
            case (state)
                IDLE: begin
`ifdef AXIS_DIGITAL_RAMP_EN
                    if (dig != '0)
                        state_n = RAMP;
`endif
                end
                MOUSE: ;
                RAMP: begin
`ifdef AXIS_DIGITAL_RAMP_EN
                    if (accx == '0 && accy == '0 && dig == '0) begin
                        state_n = IDLE;
                    end else if (tick) begin
                        accx_n = AW1'(ramp_axis(int'(accx), dig[0], dig[1]));
                        accy_n = AW1'(ramp_axis(int'(accy), dig[3], dig[2]));
                    end
`else
                    state_n = IDLE;
`endif
                end
                default: state_n = IDLE;
            endcase
        end
        if (state_n != MOUSE)
            btn_n = '0;
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            state   <= IDLE;
            accx    <= '0;
            accy    <= '0;
            ax_out  <= '0;
            ay_out  <= '0;
            btn_out <= '0;
            emu_act <= 1'b0;
        end else begin
            state   <= state_n;
            accx    <= accx_n;
            accy    <= accy_n;
            btn_out <= btn_n;
            emu_act <= (state_n != IDLE);
            if (halt) begin
                ax_out <= '0;
                ay_out <= '0;
            end else if (state_n == IDLE) begin
                ax_out <= ana[AW-1:0];
                ay_out <= ana[2*AW-1:AW];
            end else begin
                ax_out <= accx_n[AW-1:0];
                ay_out <= accy_n[AW-1:0];
            end
        end
    end

endmodule

// File: rtl/analog_axis_emu.sv
// analog_axis_emu
// Per-channel analog-axis generator: passes real sticks through, or
// synthesises axes from PS/2 mouse deltas, or ramps from digital input.
// Optional feature macro: AXIS_DIGITAL_RAMP_EN (digital ramp + tick counter).
// Ports:
//   CLK_VIDEO, reset : clock, synchronous active-high reset
//   mouse_pkt        : PS/2 packet, [24] toggles once per new packet
//   mouse_sel        : channel receiving mouse packets
//   ana_in           : real sticks, per channel {Y,X}
//   dig_in           : digital directions, per channel {U,D,L,R}
//   halt             : forces every channel to IDLE with zero outputs
//   ax_out, ay_out   : signed axis values per channel
//   btn_out          : mouse buttons per channel
//   emu_act          : channel is emulating (MOUSE or RAMP)
module analog_axis_emu
    import analog_axis_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int AW        = 8,
    parameter int MAX_STEP  = 10,
    parameter int RAMP_DIV  = 4096,
    parameter int RAMP_STEP = 2
) (
    input  logic                                CLK_VIDEO,
    input  logic                                reset,
    input  logic [24:0]                         mouse_pkt,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] mouse_sel,
    input  logic [NCH*2*AW-1:0]                 ana_in,
    input  logic [NCH*4-1:0]                    dig_in,
    input  logic                                halt,
    output logic [NCH*AW-1:0]                   ax_out,
    output logic [NCH*AW-1:0]                   ay_out,
    output logic [NCH*2-1:0]                    btn_out,
    output logic [NCH-1:0]                      emu_act
);

    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              strb_copy;
    logic              stb_q;
    logic [SW-1:0]     sel_q;
    logic signed [8:0] dx_q, dy_q;
    logic [1:0]        btn_q;
    logic              tick;
    logic [NCH*4-1:0]  dig_int;
    logic              unused_pkt;

    assign unused_pkt = ^{mouse_pkt[16], mouse_pkt[8], mouse_pkt[7:6], mouse_pkt[3:2]};

    // Packet is captured on the edge that sees the toggle; channels apply
    // it one edge later. Reset reloads the copy so a toggle during reset
    // never produces an update.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            strb_copy <= mouse_pkt[24];
            stb_q     <= 1'b0;
            sel_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            btn_q     <= '0;
        end else begin
            strb_copy <= mouse_pkt[24];
            stb_q     <= (mouse_pkt[24] != strb_copy);
            sel_q     <= mouse_sel;
            dx_q      <= {mouse_pkt[4], mouse_pkt[4], mouse_pkt[15:9]};
            dy_q      <= {mouse_pkt[5], mouse_pkt[5], mouse_pkt[23:17]};
            btn_q     <= mouse_pkt[1:0];
        end
    end

`ifdef AXIS_DIGITAL_RAMP_EN
    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    logic [CW-1:0] tick_cnt;

    assign tick    = (tick_cnt == CW'(RAMP_DIV - 1));
    assign dig_int = dig_in;

    always_ff @(posedge CLK_VIDEO) begin
        if (reset || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end
`else
    assign tick    = 1'b0;
    assign dig_int = '0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        analog_axis_chan #(
            .AW        (AW),
            .MAX_STEP  (MAX_STEP),
            .RAMP_STEP (RAMP_STEP)
        ) u_chan (
            .CLK_VIDEO (CLK_VIDEO),
            .reset     (reset),
            .stb       (stb_q && (sel_q == SW'(i))),
            .dx        (dx_q),
            .dy        (dy_q),
            .btn       (btn_q),
            .ana       (ana_in[i*2*AW +: 2*AW]),
            .dig       (dig_int[i*4 +: 4]),
            .halt      (halt),
            .tick      (tick),
            .ax_out    (ax_out[i*AW +: AW]),
            .ay_out    (ay_out[i*AW +: AW]),
            .btn_out   (btn_out[i*2 +: 2]),
            .emu_act   (emu_act[i])
        );
    end

endmodule
